sdf_fft_stage: RTL and testbench
================================

# sdf_fft_stage

Parametrised radix-2 single-path delay-feedback (R2SDF) decimation-in-frequency FFT stage on complex streaming samples. It generalises the fixed 8-point serial datapath to any power-of-two delay depth, complex data, and a valid-qualified (stallable) stream. It adds optional per-stage scaling, saturation and inverse-transform mode. Stages cascade with LOG2_DEPTH = log2(N)-1 down to 0+1 to form an N-point FFT; twiddles come from an external combinational ROM addressed by this block.

## Interface
- W, 16: data width per component (signed two's complement, re and im)
- LOG2_DEPTH, 2: log2 of delay-line depth D; stage frame = 2D samples; must be ≥1
- TW_W, 16: twiddle component width, signed; 1.0 = 2^(TW_W-2)
- SCALE, 1: 1 = arithmetic right-shift by 1 on butterfly outputs; 0 = no shift, saturate to W
- clk  in  1  clock; all state changes on rising edge
- clear  in  1  synchronous, active-high reset
- inv  in  1  1 = inverse transform (twiddle conjugated); sampled only while clear=1
- in_valid  in  1  input sample strobe; one sample accepted per cycle it is high
- in_re, in_im  in  W  input sample
- tw_addr  out  LOG2_DEPTH  twiddle index n, 0..D-1 (combinational from counter)
- tw_re, tw_im  in  TW_W  ROM response for tw_addr, same cycle: cos(2πn/2D), −sin(2πn/2D), scaled
- out_valid  out  1  output sample strobe
- out_re, out_im  out  W  output sample

## Operation
- Sample counter cnt, LOG2_DEPTH+1 bits, increments (wraps 2D-1→0) on each accepted sample only; cnt[LOG2_DEPTH] = phase.
- Delay line: D complex entries, W+1 bits each, shifts only on accepted samples.
- Phase 0 (cnt < D): input pushed into delay line unchanged; delay-line output d (previous frame's difference) multiplied by twiddle index cnt[LOG2_DEPTH-1:0] and emitted.
- Phase 1 (cnt ≥ D): butterfly with d = x[n], input = x[n+D]; sum d+in emitted (after scale/saturate); difference d−in pushed into delay line.
- Complex multiply: re = (dr·tr − di·ti) >>> (TW_W-2), im = (dr·ti + di·tr) >>> (TW_W-2); arithmetic shift (truncate toward −∞), then saturate to W.
- inv_q: when 1, ti replaced by −tw_im before multiply.
- Butterfly: full-precision W+1 sum/difference; SCALE=1 → >>>1 then fits W; SCALE=0 → saturate to [−2^(W-1), 2^(W-1)−1]. Difference stored unscaled-then-scaled identically to sum.
- primed flag: set on first accepted sample with cnt = D; outputs are suppressed before it (delay line holds no valid data).
- Last frame's D differences emerge only as the next frame's phase-0 inputs are accepted; flush by feeding D zero samples.

## Timing
- Output registered: sample accepted in cycle t (with primed true or becoming true) → out_valid=1 and data in cycle t+1. Otherwise out_valid=0 at t+1; out_re/out_im hold.
- Stream latency: D accepted samples + 1 clock. Output order: sums n=0..D-1, then twiddled differences n=0..D-1.
- in_valid=0: counter, delay line, primed frozen; no output.
- clear=1 (any time, including mid-frame, overrides in_valid): cnt=0, delay line=0, primed=0, out_valid=0, out_re=out_im=0, inv_q←inv. Sample presented with clear is discarded.
- tw_addr valid combinationally every cycle; only consumed in phase 0.

## Test plan
- D=4, SCALE=0, TW_W=16: frame re = 100,0,0,0,0,0,0,0 then 4 zeros → outputs re 100,0,0,0,100,0,0,0, im all 0; out_valid first high cycle after 5th sample.
- SCALE=1: constant 50+0j ×8 then 4 zeros → 50,50,50,50 then 0,0,0,0.
- SCALE=0, re = 0..7, im 0, then 4 zeros: twiddled diff n=0 → −4+0j; n=2 → 0+4j; with inv=1 (applied via clear) n=2 → 0−4j.
- W=8, SCALE=0: x[0]=100, x[4]=100 → sum saturates to 127; x[4]=−100 gives diff 200 → 127 after twiddle n=0.
- Random in_valid gaps over 3 frames → out sequence identical to gap-free run; out_valid count equals accepted samples minus D.
- clear asserted at cnt=6 → next cycle out_valid=0, outputs 0; restart frame reproduces first-scenario result exactly.

Source files
------------

// File: rtl/sdf_fft_stage.sv
// sdf_fft_stage: radix-2 single-path delay-feedback DIF FFT stage on a valid-qualified complex stream.
//   clk                   clock, all state changes on rising edge
//   clear                 synchronous active-high reset; also latches inv into inv_q
//   inv                   1 = inverse transform (twiddle conjugated), sampled while clear=1
//   in_valid/in_re/in_im  input sample strobe and data
//   tw_addr               twiddle index n = low bits of the sample counter
//   tw_re/tw_im           same-cycle ROM response: cos(2*pi*n/2D), -sin(2*pi*n/2D), 1.0 = 2^(TW_W-2)
//   out_valid/out_re/out_im registered output strobe and data
module sdf_fft_stage #(
  parameter int W = 16,
  parameter int LOG2_DEPTH = 2,
  parameter int TW_W = 16,
  parameter int SCALE = 1
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  inv,
  input  logic                  in_valid,
  input  logic signed [W-1:0]   in_re,
  input  logic signed [W-1:0]   in_im,
  output logic [LOG2_DEPTH-1:0] tw_addr,
  input  logic signed [TW_W-1:0] tw_re,
  input  logic signed [TW_W-1:0] tw_im,
  output logic                  out_valid,
  output logic signed [W-1:0]   out_re,
  output logic signed [W-1:0]   out_im
);
  localparam int D = 1 << LOG2_DEPTH;
  localparam int PW = W + TW_W + 3;
  localparam logic [LOG2_DEPTH:0] DV = {1'b1, {LOG2_DEPTH{1'b0}}};
  localparam logic signed [PW-1:0] MAXV = {{(PW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV = ~MAXV;
  function automatic logic signed [W-1:0] sat(input logic signed [PW-1:0] x);
    return x > MAXV ? MAXV[W-1:0] : x < MINV ? MINV[W-1:0] : x[W-1:0];
  endfunction
  function automatic logic signed [W-1:0] bfly(input logic signed [PW-1:0] x);
    return sat(SCALE != 0 ? x >>> 1 : x);
  endfunction
  logic [LOG2_DEPTH:0] cnt_q, cnt_d;
  logic primed_q, primed_d, inv_q;
  logic signed [W:0] dre_q [D];
  logic signed [W:0] dim_q [D];
  logic out_valid_q;
  logic signed [W-1:0] out_re_q, out_im_q, out_re_d, out_im_d;
  logic signed [PW-1:0] dr, di, xr, xi, tr, ti, mr, mi;
  logic signed [W-1:0] sr, si, fr, fi;
  logic signed [W:0] push_re, push_im;
  logic acc, ph, emit;
  assign acc = in_valid & ~clear;
  assign ph = cnt_q[LOG2_DEPTH];
  assign tw_addr = cnt_q[LOG2_DEPTH-1:0];
  assign dr = PW'(dre_q[D-1]);
  assign di = PW'(dim_q[D-1]);
  assign xr = PW'(in_re);
  assign xi = PW'(in_im);
  assign tr = PW'(tw_re);
  assign ti = inv_q ? -PW'(tw_im) : PW'(tw_im);
  assign mr = (dr * tr - di * ti) >>> (TW_W - 2);
  assign mi = (dr * ti + di * tr) >>> (TW_W - 2);
  assign sr = bfly(dr + xr);
  assign si = bfly(di + xi);
  assign fr = bfly(dr - xr);
  assign fi = bfly(di - xi);
  // Phase 1 feeds back the scaled difference; phase 0 stores the raw input for the next butterfly.
  assign push_re = ph ? (W+1)'(fr) : (W+1)'(in_re);
  assign push_im = ph ? (W+1)'(fi) : (W+1)'(in_im);
  // The delay line holds no real data until the first phase-1 sample of a fresh stream.
  assign emit = acc & (primed_q | cnt_q == DV);
  assign out_re_d = ph ? sr : sat(mr);
  assign out_im_d = ph ? si : sat(mi);
  assign cnt_d = acc ? cnt_q + (LOG2_DEPTH+1)'(1) : cnt_q;
  assign primed_d = primed_q | emit;
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_q <= '0;
      primed_q <= 1'b0;
      inv_q <= inv;
      out_valid_q <= 1'b0;
      out_re_q <= '0;
      out_im_q <= '0;
      for (int i = 0; i < D; i++) begin
        dre_q[i] <= '0;
        dim_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      primed_q <= primed_d;
      out_valid_q <= emit;
      if (emit) begin
        out_re_q <= out_re_d;
        out_im_q <= out_im_d;
      end
      if (acc) begin
        dre_q[0] <= push_re;
        dim_q[0] <= push_im;
        for (int i = 1; i < D; i++) begin
          dre_q[i] <= dre_q[i-1];
          dim_q[i] <= dim_q[i-1];
        end
      end
    end
  end
  assign out_valid = out_valid_q;
  assign out_re = out_re_q;
  assign out_im = out_im_q;
endmodule

// File: tb/tb_sdf_fft_stage.sv
// tb_sdf_fft_stage: scoreboard bench for sdf_fft_stage against a frame-level reference model.
module tb_sdf_fft_stage;
  localparam int W = 16;
  localparam int L = 2;
  localparam int TW_W = 16;
  localparam int SCALE = 0;
  localparam int D = 1 << L;
  localparam longint MAXV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W - 1));
  logic clk = 0, clear = 1, inv = 0, in_valid = 0;
  logic signed [W-1:0] in_re = 0, in_im = 0;
  logic [L-1:0] tw_addr;
  logic signed [TW_W-1:0] tw_re, tw_im;
  logic out_valid;
  logic signed [W-1:0] out_re, out_im;
  int tw_re_t [D];
  int tw_im_t [D];
  longint exp_re [$];
  longint exp_im [$];
  int checks = 0, passes = 0, nvalid = 0, acc_n = 0;
  int fk = 0;
  bit m_primed = 0, m_inv = 0;
  longint fr_re [2*D];
  longint fr_im [2*D];
  longint df_re [D];
  longint df_im [D];
  sdf_fft_stage #(.W(W), .LOG2_DEPTH(L), .TW_W(TW_W), .SCALE(SCALE)) dut (
    .clk(clk), .clear(clear), .inv(inv), .in_valid(in_valid),
    .in_re(in_re), .in_im(in_im), .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im)
  );
  always #5 clk = ~clk;
  initial begin
    for (int n = 0; n < D; n++) begin
      real a;
      a = 2.0 * 3.14159265358979 * n / (2.0 * D);
      tw_re_t[n] = $rtoi($floor($cos(a) * (2.0 ** (TW_W - 2)) + 0.5));
      tw_im_t[n] = $rtoi($floor(-$sin(a) * (2.0 ** (TW_W - 2)) + 0.5));
    end
  end
  assign tw_re = tw_re_t[tw_addr][TW_W-1:0];
  assign tw_im = tw_im_t[tw_addr][TW_W-1:0];
  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask
  function automatic longint sat(input longint x);
    return x > MAXV ? MAXV : x < MINV ? MINV : x;
  endfunction
  function automatic longint bf(input longint x);
    return SCALE != 0 ? x >>> 1 : sat(x);
  endfunction
  task automatic model_clear(input bit iv);
    fk = 0;
    m_primed = 0;
    m_inv = iv;
    for (int n = 0; n < D; n++) begin
      df_re[n] = 0;
      df_im[n] = 0;
    end
  endtask
  // Frame view: first half is buffered; second half yields X[n]+X[n+D] now and twiddled X[n]-X[n+D] next frame.
  task automatic model_sample(input longint re, input longint im);
    if (fk < D) begin
      if (m_primed) begin
        longint tr, ti;
        tr = tw_re_t[fk];
        ti = m_inv ? -tw_im_t[fk] : tw_im_t[fk];
        exp_re.push_back(sat((df_re[fk] * tr - df_im[fk] * ti) >>> (TW_W - 2)));
        exp_im.push_back(sat((df_re[fk] * ti + df_im[fk] * tr) >>> (TW_W - 2)));
      end
    end else begin
      int n;
      n = fk - D;
      m_primed = 1;
      exp_re.push_back(bf(fr_re[n] + re));
      exp_im.push_back(bf(fr_im[n] + im));
      df_re[n] = bf(fr_re[n] - re);
      df_im[n] = bf(fr_im[n] - im);
    end
    fr_re[fk] = re;
    fr_im[fk] = im;
    fk = (fk + 1) % (2 * D);
  endtask
  task automatic step(input bit v, input longint re, input longint im, input bit clr = 0, input bit iv = 0);
    clear = clr;
    inv = iv;
    in_valid = v;
    in_re = re[W-1:0];
    in_im = im[W-1:0];
    if (clr) begin
      model_clear(iv);
      acc_n = 0;
      nvalid = 0;
    end else if (v) begin
      model_sample(re, im);
      acc_n++;
    end
    @(posedge clk);
    #1;
    clear = 0;
    in_valid = 0;
  endtask
  task automatic drain(input string name);
    @(negedge clk);
    #1;
    chk(name, exp_re.size(), 0);
  endtask
  always @(negedge clk) begin
    if (out_valid) begin
      nvalid++;
      chk("sb_avail", exp_re.size() != 0, 1);
      if (exp_re.size() != 0) begin
        chk("out_re", out_re, exp_re.pop_front());
        chk("out_im", out_im, exp_im.pop_front());
      end
    end
  end
  task automatic run_impulse();
    for (int k = 0; k < 3 * D; k++) begin
      step(1, k == 0 ? 100 : 0, 0);
      if (k == D - 1) chk("imp_no_early_valid", out_valid, 0);
      if (k == D) begin
        chk("imp_first_valid", out_valid, 1);
        chk("imp_first_re", out_re, 100);
      end
      if (k == 2 * D) chk("imp_diff_re", out_re, 100);
    end
    drain("imp_drained");
  endtask
  task automatic run_ramp(input bit iv);
    step(0, 0, 0, 1, iv);
    for (int k = 0; k < 3 * D; k++) begin
      step(1, k < 2 * D ? k : 0, 0);
      if (k == 2 * D) chk("ramp_diff0_re", out_re, -4);
      if (k == 2 * D + 2) begin
        chk("ramp_diff2_re", out_re, 0);
        chk("ramp_diff2_im", out_im, iv ? -4 : 4);
      end
    end
    drain("ramp_drained");
  endtask
  initial begin
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_re", out_re, 0);
    chk("rst_im", out_im, 0);
    run_impulse();
    run_ramp(0);
    run_ramp(1);
    step(0, 0, 0, 1);
    for (int k = 0; k < 3 * D; k++) begin
      longint v;
      v = k == 0 || k == 1 || k == D ? 30000 : k == D + 1 ? -30000 : 0;
      step(1, v, 0);
      if (k == D) chk("sat_sum", out_re, MAXV);
      if (k == 2 * D + 1) chk("sat_diff_valid", out_valid, 1);
    end
    drain("sat_drained");
    step(0, 0, 0, 1);
    for (int k = 0; k < 6; k++) step(1, k == 0 ? 100 : 0, 0);
    step(1, 55, 66, 1);
    chk("clr_valid", out_valid, 0);
    chk("clr_re", out_re, 0);
    chk("clr_im", out_im, 0);
    run_impulse();
    for (int r = 0; r < 2; r++) begin
      step(0, 0, 0, 1, r[0]);
      for (int k = 0; k < 4 * D; k++) begin
        while ($urandom_range(2) == 0) step(0, $urandom_range(999), $urandom_range(999));
        if (k < 3 * D) step(1, longint'($urandom_range(65535)) - 32768, longint'($urandom_range(65535)) - 32768);
        else step(1, 0, 0);
      end
      drain("rnd_drained");
      chk("rnd_valid_count", nvalid, acc_n - D);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
